// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0, req1;
  logic          we0, we1;
  logic          lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_wdata, mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the data memory (option macro: DMEM_ARB_FIXED_PRIO_EN)
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          CLK,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {NONE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_e;
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;
  logic [3:0]    cnt_q, cnt_d;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic          prio1_q, prio1_d;
`endif
  logic          gnt0, gnt1, gnt_any, gnt_port, gnt_we, gnt_lock, own_lock;
  logic [3:0]    cnt_inc;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;

  logic          mem_read_q, mem_write_q, acc_port_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  // Pick this cycle's winner and work out the next owner, tie pointer and burst count
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cnt_inc = 4'd0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    // The post-release favour for port 1 lasts for one unowned cycle only
    prio1_d = (owner_q == NONE) ? 1'b0 : prio1_q;
`endif
    if (reset) begin
      case (owner_q)
        OWN0: begin
          gnt0 = bus.req0;
          gnt1 = !bus.req0 && bus.req1;
        end
        OWN1: begin
          gnt1 = bus.req1;
          gnt0 = !bus.req1 && bus.req0;
        end
        default: begin
          if (bus.req0 && bus.req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            gnt1 = prio1_q;
`else
            gnt1 = !last_q;
`endif
            gnt0 = !gnt1;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
        end
      endcase
    end

    gnt_any   = gnt0 | gnt1;
    gnt_port  = gnt1;
    gnt_we    = gnt1 ? bus.we1    : bus.we0;
    gnt_lock  = gnt1 ? bus.lock1  : bus.lock0;
    gnt_addr  = gnt1 ? bus.addr1  : bus.addr0;
    gnt_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
    own_lock  = (owner_q == OWN1) ? bus.lock1 : bus.lock0;

    if (gnt_any) last_d = gnt_port;

    if (owner_q != NONE && !own_lock) begin
      owner_d = NONE;
      cnt_d   = 4'd0;
    end else if (gnt_any && gnt_lock && (owner_q == NONE || ((owner_q == OWN1) == gnt_port))) begin
      cnt_inc = (owner_q == NONE) ? 4'd1 : cnt_q + 4'd1;
      if (cnt_inc >= BURST_MAX) begin
        // Forced release: pointing last at the holder hands the next tie to the other port
        owner_d = NONE;
        cnt_d   = 4'd0;
        last_d  = gnt_port;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        if (!gnt_port) prio1_d = 1'b1;
`endif
      end else begin
        owner_d = gnt_port ? OWN1 : OWN0;
        cnt_d   = cnt_inc;
      end
    end
  end

  // Owner FSM state, tie pointer and burst counter
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      owner_q <= NONE;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      prio1_q <= 1'b0;
`endif
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      prio1_q <= prio1_d;
`endif
    end
  end

  // Capture the granted request and present it to the memory in the following cycle
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      acc_port_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_read_q  <= gnt_any && !gnt_we;
      mem_write_q <= gnt_any && gnt_we;
      if (gnt_any) begin
        acc_port_q  <= gnt_port;
        mem_addr_q  <= gnt_addr;
        mem_wdata_q <= gnt_wdata;
      end
    end
  end

  // Register memory read data at the end of the access cycle and pulse rvalid for its port
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= mem_read_q && !acc_port_q;
      rvalid1_q <= mem_read_q && acc_port_q;
      if (mem_read_q && !acc_port_q) rdata0_q <= bus.mem_rdata;
      if (mem_read_q && acc_port_q)  rdata1_q <= bus.mem_rdata;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MAX_BURST = 4;

  logic CLK = 1'b0;
  logic reset;
  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  // memory with a bench-side load port
  logic [DW-1:0] mem [0:255];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  always @(posedge CLK) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic l0, input logic l1, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    bus.req0 = r0;  bus.req1 = r1;
    bus.we0 = w0;   bus.we1 = w1;
    bus.lock0 = l0; bus.lock1 = l1;
    bus.addr0 = a0; bus.addr1 = a1;
    bus.wdata0 = d0; bus.wdata1 = d1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // directed table: {r0, r1, l0, exp gnt0, exp gnt1, exp mem_read}
  typedef struct {
    logic r0, r1, l0, eg0, eg1, erd;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(input logic [5:0] b);
    vec_t v;
    v.r0 = b[5]; v.r1 = b[4]; v.l0 = b[3];
    v.eg0 = b[2]; v.eg1 = b[1]; v.erd = b[0];
    return v;
  endfunction

  // reference model state
  int m_owner, m_last, m_cnt;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  bit m_prio1;
`endif
  logic [7:0] shadow [0:255];
  bit         s1_v, s1_we, s2_v;
  int         s1_p, s2_p;
  logic [7:0] s1_a, s1_wd, s1_d, s2_d;
  logic [7:0] hold [2];

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_cnt = 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    m_prio1 = 1'b0;
`endif
    s1_v = 1'b0; s1_we = 1'b0; s2_v = 1'b0; s1_p = 0; s2_p = 0;
    s1_a = '0; s1_wd = '0; s1_d = '0; s2_d = '0;
    hold[0] = '0; hold[1] = '0;
  endtask

  task automatic rand_cycle();
    logic       r[2], w[2], l[2];
    logic [7:0] a[2], d[2];
    int         g;
    for (int p = 0; p < 2; p++) begin
      r[p] = ($urandom_range(0, 9) < 6);
      w[p] = $urandom_range(0, 1) == 1;
      l[p] = ($urandom_range(0, 9) < 6);
      a[p] = 8'($urandom_range(0, 7));
      d[p] = 8'($urandom_range(0, 255));
    end
    drive(r[0], r[1], w[0], w[1], l[0], l[1], a[0], a[1], d[0], d[1]);
    @(negedge CLK);

    g = -1;
    if (m_owner >= 0) begin
      if (r[m_owner]) g = m_owner;
      else if (r[1 - m_owner]) g = 1 - m_owner;
    end else if (r[0] && r[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      g = m_prio1 ? 1 : 0;
`else
      g = 1 - m_last;
`endif
    end else if (r[0]) g = 0;
    else if (r[1]) g = 1;

    if (s2_v) hold[s2_p] = s2_d;
    chk("rnd_gnt0", bus.gnt0, g == 0);
    chk("rnd_gnt1", bus.gnt1, g == 1);
    chk("rnd_mem_read", bus.mem_read, s1_v && !s1_we);
    chk("rnd_mem_write", bus.mem_write, s1_v && s1_we);
    if (s1_v) chk("rnd_mem_addr", bus.mem_addr, s1_a);
    if (s1_v && s1_we) chk("rnd_mem_wdata", bus.mem_wdata, s1_wd);
    chk("rnd_rvalid0", bus.rvalid0, s2_v && s2_p == 0);
    chk("rnd_rvalid1", bus.rvalid1, s2_v && s2_p == 1);
    chk("rnd_rdata0", bus.rdata0, hold[0]);
    chk("rnd_rdata1", bus.rdata1, hold[1]);

    s2_v = s1_v && !s1_we; s2_p = s1_p; s2_d = s1_d;
    s1_v = (g >= 0);
    if (g >= 0) begin
      s1_we = w[g]; s1_p = g; s1_a = a[g]; s1_wd = d[g];
      if (w[g]) shadow[a[g]] = d[g];
      else s1_d = shadow[a[g]];
      m_last = g;
    end
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (m_owner < 0) m_prio1 = 1'b0;
`endif
    if (m_owner >= 0 && !l[m_owner]) begin
      m_owner = -1; m_cnt = 0;
    end else if (g >= 0 && l[g] && (m_owner < 0 || m_owner == g)) begin
      m_cnt = (m_owner < 0) ? 1 : m_cnt + 1;
      if (m_cnt >= MAX_BURST) begin
        m_owner = -1; m_cnt = 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        if (g == 0) m_prio1 = 1'b1;
`endif
      end else m_owner = g;
    end
    tick();
  endtask

  initial begin
    tbl[0]  = mk(6'b110_100);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    tbl[1]  = mk(6'b110_101);
    tbl[3]  = mk(6'b110_101);
`else
    tbl[1]  = mk(6'b110_011);
    tbl[3]  = mk(6'b110_011);
`endif
    tbl[2]  = mk(6'b110_101);
    tbl[4]  = mk(6'b111_101);
    tbl[5]  = mk(6'b111_101);
    tbl[6]  = mk(6'b111_101);
    tbl[7]  = mk(6'b111_101);
    tbl[8]  = mk(6'b111_011);
    tbl[9]  = mk(6'b111_101);
    tbl[10] = mk(6'b010_011);
    tbl[11] = mk(6'b110_101);
    tbl[12] = mk(6'b010_011);

    reset = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    drive_idle();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    load(8'd16, 8'd254);
    #1;
    chk("rst_gnt0", bus.gnt0, 1'b0);
    chk("rst_gnt1", bus.gnt1, 1'b0);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 8'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 8'd0);
    chk("rst_rvalid0", bus.rvalid0, 1'b0);
    chk("rst_rdata1", bus.rdata1, 8'd0);
    drive_idle();
    tick();
    reset = 1'b1;

    // tie round-robin, lock burst cap, release and retained-ownership rows
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r0, tbl[i].r1, 1'b0, 1'b0, tbl[i].l0, 1'b0, 8'd16, 8'd17, 8'd0, 8'd0);
      @(negedge CLK);
      chk($sformatf("tbl%0d_gnt0", i), bus.gnt0, tbl[i].eg0);
      chk($sformatf("tbl%0d_gnt1", i), bus.gnt1, tbl[i].eg1);
      chk($sformatf("tbl%0d_mem_read", i), bus.mem_read, tbl[i].erd);
      tick();
    end

    // single read from port 0
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd16, 8'd0, 8'd0, 8'd0);
    @(negedge CLK);
    chk("rd_gnt0", bus.gnt0, 1'b1);
    chk("rd_gnt1", bus.gnt1, 1'b0);
    tick(); drive_idle(); @(negedge CLK);
    chk("rd_mem_read", bus.mem_read, 1'b1);
    chk("rd_mem_addr", bus.mem_addr, 8'd16);
    chk("rd_rvalid0_early", bus.rvalid0, 1'b0);
    tick(); @(negedge CLK);
    chk("rd_rvalid0", bus.rvalid0, 1'b1);
    chk("rd_rdata0", bus.rdata0, 8'd254);
    chk("rd_mem_read_idle", bus.mem_read, 1'b0);
    tick(); @(negedge CLK);
    chk("rd_rvalid0_pulse", bus.rvalid0, 1'b0);
    chk("rd_rdata0_hold", bus.rdata0, 8'd254);
    tick();

    // port 1 write then read of the same address
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd200, 8'd0, 8'hA5);
    @(negedge CLK);
    chk("wr_gnt1", bus.gnt1, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd200, 8'd0, 8'd0);
    @(negedge CLK);
    chk("wr_rd_gnt1", bus.gnt1, 1'b1);
    chk("wr_mem_write", bus.mem_write, 1'b1);
    chk("wr_mem_wdata", bus.mem_wdata, 8'hA5);
    chk("wr_mem_addr", bus.mem_addr, 8'd200);
    tick(); drive_idle(); @(negedge CLK);
    chk("wr_rd_mem_read", bus.mem_read, 1'b1);
    chk("wr_rd_mem_write", bus.mem_write, 1'b0);
    tick(); @(negedge CLK);
    chk("wr_rd_rvalid1", bus.rvalid1, 1'b1);
    chk("wr_rd_rdata1", bus.rdata1, 8'hA5);
    chk("wr_rd_rvalid0", bus.rvalid0, 1'b0);
    tick();

    // asynchronous reset during an owned burst with a read in flight
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd16, 8'd0, 8'd0, 8'd0);
    @(negedge CLK);
    chk("ar_gnt0_a", bus.gnt0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd17, 8'd0, 8'd0, 8'd0);
    @(negedge CLK);
    chk("ar_gnt0_b", bus.gnt0, 1'b1);
    chk("ar_mem_read_pre", bus.mem_read, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("ar_gnt0", bus.gnt0, 1'b0);
    chk("ar_mem_read", bus.mem_read, 1'b0);
    chk("ar_mem_write", bus.mem_write, 1'b0);
    chk("ar_rvalid0", bus.rvalid0, 1'b0);
    chk("ar_rdata0", bus.rdata0, 8'd0);
    tick();
    drive_idle();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk($sformatf("ar_post_rvalid0_%0d", i), bus.rvalid0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2, 8'd0, 8'd0);
    @(negedge CLK);
    chk("ar_tie_gnt0", bus.gnt0, 1'b1);
    chk("ar_tie_gnt1", bus.gnt1, 1'b0);
    tick();

    // randomized traffic against the reference model
    drive_idle();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      shadow[i] = 8'($urandom_range(0, 255));
      load(8'(i), shadow[i]);
    end
    tick();
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) rand_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-pointer 256x8 data memory.
- Port 0 is the core load/store unit; port 1 is the loader/debug engine.
- Arbitrates each cycle, captures the winning request, drives the memory one cycle later, and returns registered read data with a valid strobe.
- Supports bounded lock bursts so a port can own memory for multi-byte sequences.

Parameters:
- AW, 8, address width (memory depth 2^AW).
- DW, 8, data width.
- MAX_BURST, 4, max consecutive grants under lock before forced release (range 1..15).

Ports:
- CLK  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  request ownership after this grant
- addr0 / addr1  in  AW  byte address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  combinational accept, same cycle as req
- rvalid0 / rvalid1  out  1  read data valid, one-cycle pulse
- rdata0 / rdata1  out  DW  registered read data
- mem_addr  out  AW  to memory DataAddress
- mem_read  out  1  to memory ReadMem
- mem_write  out  1  to memory WriteMem
- mem_wdata  out  DW  to memory write data
- mem_rdata  in  DW  from memory read data (combinational)

Behaviour:
- Reset (reset=0, asynchronous):
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - rvalid0/1=0, rdata0/1=0.
  - owner=NONE, last=1, so port 0 wins the first tie.
  - burst count=0.
  - While reset=0: gnt0/1=0 regardless of req.
- Owner FSM states: NONE, OWN0, OWN1.
- Grant selection, cycle N, combinational:
  - OWNx and reqx=1: grant x.
  - OWNx and reqx=0: no grant to x; the other port may still be granted. Ownership is retained, so idle cycles do not release it.
  - NONE: only one req set, grant it. Both set, grant !last.
  - At most one gnt per cycle.
  - A request is consumed in the cycle its gnt=1. The requester must drop req or present a new request in N+1.
- Capture on the clock edge ending N, if a grant was made:
  - Capture addr, wdata, we and the port id.
  - last <= granted port.
- Cycle N+1 (memory access):
  - mem_addr and mem_wdata carry the captured values.
  - mem_write=we, mem_read=!we.
  - With no capture, mem_read=mem_write=0 and addr/wdata hold their previous values.
- Read return:
  - mem_rdata is registered into rdataX at the end of N+1.
  - rvalidX=1 for exactly cycle N+2.
  - Read latency is 2 cycles from gnt. Throughput is one access per cycle.
  - rdataX holds its value until the next read completes for that port.
- Lock transitions:
  - Grant to x with lockx=1: next state OWNx, count <= count+1 (count <= 1 on entry from NONE).
  - lockx=0 at any cycle in OWNx: NONE next cycle.
  - count reaches MAX_BURST: forced NONE, count <= 0, last <= x, so the other port wins a tie.
  - Grant under NONE with lock=0: stays NONE.
- Write-then-read same address in consecutive grants: the read returns the new value, since the write completes in N+1 before the read accesses memory in N+2.
- Reset mid-burst: all state clears immediately. Any in-flight rvalid is suppressed; no rvalid pulse follows reset release.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: under NONE, port 0 always wins ties and last is ignored. Lock and MAX_BURST forced release are unchanged; after a forced release of OWN0, port 1 gets exactly one priority grant if requesting.
- Undefined: round-robin as above.

Test Plan:
- Single read: reset, memory pre-loaded M[16]=254; req0=1, we0=0, addr0=16 for one cycle -> gnt0 same cycle; mem_read=1, mem_addr=16 next cycle; rvalid0=1, rdata0=254 in the cycle after.
- Tie round-robin: req0=req1=1 for 4 cycles -> grants alternate 0,1,0,1, starting with port 0.
- Write then read: port 1 writes 0xA5 to addr 200, then reads 200 the next cycle -> mem_write=1 with mem_wdata=0xA5, then rdata1=0xA5 with rvalid1 pulsed.
- Lock burst cap (MAX_BURST=4): port 0 lock0=1, req0=1 continuously, req1=1 -> port 0 gets 4 grants, then gnt1=1 on the next cycle.
- Async reset mid-burst: drop reset during OWN0 with a read in flight -> gnt, mem_read, mem_write and rvalid go 0 immediately; after release, first tie grants port 0.
- DMEM_ARB_FIXED_PRIO_EN defined: req0=req1=1 for 3 cycles -> gnt0 all 3 cycles, gnt1=0.
